// File: rtl/seta_lane_accumulator.sv
// seta_lane_accumulator
//   Multi-lane streaming accumulator built on the SETA approximate adder. Every lane sums the
//   unsigned samples of one frame into its own ACC_WIDTH accumulator. The low K bits of each add
//   are approximated. K is chosen per frame, and K=0 gives an exact add. Each lane can either
//   saturate or wrap on carry-out, and keeps a sticky overflow flag for the frame.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   imp_sel        requested K, clamped to MAX_IMPRECISE, latched on the first beat of a frame
//   in_valid       input beat handshake (valid)
//   in_ready       input beat handshake (ready)
//   in_data        LANES samples, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last        final beat of the frame
//   out_valid      result handshake (valid); the result is held until out_ready is seen
//   out_ready      result handshake (ready)
//   out_data       LANES sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   out_overflow   sticky per-lane carry-out flag for the frame
//   out_k          K used for the frame
//   busy           high whenever a frame is in progress or its result is pending
module seta_lane_accumulator #(
    parameter int unsigned LANES         = 4,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned MAX_IMPRECISE = 16,
    parameter bit          SATURATE      = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [$clog2(MAX_IMPRECISE+1)-1:0]     imp_sel,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]            in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [LANES*ACC_WIDTH-1:0]             out_data,
    output logic [LANES-1:0]                       out_overflow,
    output logic [$clog2(MAX_IMPRECISE+1)-1:0]     out_k,
    output logic                                   busy
);

    localparam int unsigned    KW   = $clog2(MAX_IMPRECISE + 1);
    localparam logic [KW-1:0]  KMAX = KW'(MAX_IMPRECISE);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]                         state_q, state_d;
    logic [LANES-1:0][ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [LANES-1:0]                   ov_q, ov_d;
    logic [KW-1:0]                      k_q, k_d;
    logic [KW-1:0]                      k_clamped;
    logic [LANES-1:0][ACC_WIDTH-1:0]    x_ext;
    // Bit ACC_WIDTH of each entry is the carry-out of the SETA add.
    logic [LANES-1:0][ACC_WIDTH:0]      sum_v;

    // SETA add. The low k bits are approximated. Above them, a normal add runs with the
    // approximate carry injected at bit k. The result is {carry_out, sum}.
    function automatic logic [ACC_WIDTH:0] seta_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b,
                                                    input logic [KW-1:0]        k);
        logic [ACC_WIDTH:0] ae, be, one, and_v, low_mask, fill_mask, low, upper, sh2, sh1;
        logic               p, cin;
        ae  = {1'b0, a};
        be  = {1'b0, b};
        one = {{ACC_WIDTH{1'b0}}, 1'b1};
        if (k == '0) begin
            return ae + be;
        end
        and_v     = ae & be;
        low_mask  = (one << k) - one;
        // Bits [k-3:0] are forced high when bit k-2 generates.
        fill_mask = low_mask >> 2;
        sh2       = and_v >> (k - KW'(2));
        sh1       = and_v >> (k - KW'(1));
        p         = (k >= KW'(2)) && sh2[0];
        cin       = sh1[0];
        low       = ((ae | be) | (p ? fill_mask : '0)) & low_mask;
        upper     = (ae & ~low_mask) + (be & ~low_mask) + (cin ? (one << k) : '0);
        return upper | low;
    endfunction

    assign k_clamped = (imp_sel > KMAX) ? KMAX : imp_sel;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            x_ext[i] = ACC_WIDTH'(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
            sum_v[i] = seta_add(acc_q[i], x_ext[i], k_q);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ov_d    = ov_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Adding to zero is exact for every K, so the first beat loads directly.
                    k_d     = k_clamped;
                    ov_d    = '0;
                    acc_d   = x_ext;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (sum_v[i][ACC_WIDTH]) begin
                            ov_d[i]  = 1'b1;
                            acc_d[i] = SATURATE ? '1 : sum_v[i][ACC_WIDTH-1:0];
                        end else begin
                            acc_d[i] = sum_v[i][ACC_WIDTH-1:0];
                        end
                    end
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    ov_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ov_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ov_q    <= ov_d;
            k_q     <= k_d;
        end
    end

    // The handshake outputs are decoded from state only.
    assign in_ready     = (state_q != DONE);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign out_data     = acc_q;
    assign out_overflow = ov_q;
    assign out_k        = k_q;

endmodule

// File: tb/tb_seta_lane_accumulator.sv
// Bench for seta_lane_accumulator. Three instances share one input stream:
//   u_a  ACC_WIDTH=32, saturate
//   u_b  ACC_WIDTH=16, saturate
//   u_c  ACC_WIDTH=16, wrap
// Each instance is checked against a bit-level reference model of the SETA rules.
module tb_seta_lane_accumulator;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int KW    = 5;
    localparam int TOTW  = LANES*32 + 2*LANES*16 + 3*LANES + 3*KW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [KW-1:0]         imp_sel;
    logic                  in_valid, in_last, out_ready;
    logic [LANES*DW-1:0]   in_data;

    logic                  a_ready, a_valid, a_busy;
    logic                  b_ready, b_valid, b_busy;
    logic                  c_ready, c_valid, c_busy;
    logic [LANES*32-1:0]   a_data;
    logic [LANES*16-1:0]   b_data, c_data;
    logic [LANES-1:0]      a_ov, b_ov, c_ov;
    logic [KW-1:0]         a_k, b_k, c_k;

    int errors = 0;
    int checks = 0;

    logic [LANES*DW-1:0] beats[$];
    logic [TOTW-1:0]     exp_all;

    seta_lane_accumulator #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(32), .MAX_IMPRECISE(16),
                            .SATURATE(1'b1)) u_a (
        .clk(clk), .rst(rst), .imp_sel(imp_sel), .in_valid(in_valid), .in_ready(a_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_valid), .out_ready(out_ready),
        .out_data(a_data), .out_overflow(a_ov), .out_k(a_k), .busy(a_busy));

    seta_lane_accumulator #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(16), .MAX_IMPRECISE(16),
                            .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(rst), .imp_sel(imp_sel), .in_valid(in_valid), .in_ready(b_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .out_overflow(b_ov), .out_k(b_k), .busy(b_busy));

    seta_lane_accumulator #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(16), .MAX_IMPRECISE(16),
                            .SATURATE(1'b0)) u_c (
        .clk(clk), .rst(rst), .imp_sel(imp_sel), .in_valid(in_valid), .in_ready(c_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(c_valid), .out_ready(out_ready),
        .out_data(c_data), .out_overflow(c_ov), .out_k(c_k), .busy(c_busy));

    function automatic logic [TOTW-1:0] got_all();
        return {a_data, b_data, c_data, a_ov, b_ov, c_ov, a_k, b_k, c_k};
    endfunction

    // Reference SETA add on aw-bit operands, evaluated bit by bit from the adder's rules.
    function automatic void seta_ref(input longint unsigned a, input longint unsigned b,
                                     input int k, input int aw,
                                     output longint unsigned s, output bit c);
        longint unsigned full, low, p, cin, bitv;
        if (k == 0) begin
            full = a + b;
        end else begin
            p   = (k >= 2) ? ((a >> (k-2)) & (b >> (k-2)) & 64'd1) : 64'd0;
            low = 0;
            for (int j = 0; j < k; j++) begin
                bitv = ((a >> j) | (b >> j)) & 64'd1;
                if (j < k - 2) bitv = bitv | p;
                low = low | (bitv << j);
            end
            cin  = (a >> (k-1)) & (b >> (k-1)) & 64'd1;
            full = (((a >> k) + (b >> k) + cin) << k) | low;
        end
        c = ((full >> aw) & 64'd1) != 0;
        s = full & ((64'd1 << aw) - 1);
    endfunction

    // Build the expected output of all three instances for the frame held in beats.
    task automatic model_frame(input int ksel);
        int k, aw;
        bit sat, c, ov;
        longint unsigned acc, x, s, mask;
        logic [LANES*DW-1:0] bv;
        logic [LANES*32-1:0] ea;
        logic [LANES*16-1:0] eb, ec;
        logic [LANES-1:0]    oa, ob, oc;
        ea = '0; eb = '0; ec = '0; oa = '0; ob = '0; oc = '0;
        k = (ksel > 16) ? 16 : ksel;
        for (int cfg = 0; cfg < 3; cfg++) begin
            aw   = (cfg == 0) ? 32 : 16;
            sat  = (cfg != 2);
            mask = (64'd1 << aw) - 1;
            for (int lane = 0; lane < LANES; lane++) begin
                bv  = beats[0];
                acc = 64'(bv[lane*DW +: DW]);
                ov  = 1'b0;
                for (int b = 1; b < beats.size(); b++) begin
                    bv = beats[b];
                    x  = 64'(bv[lane*DW +: DW]);
                    seta_ref(acc, x, k, aw, s, c);
                    if (c) ov = 1'b1;
                    acc = (c && sat) ? mask : s;
                end
                case (cfg)
                    0: begin ea[lane*32 +: 32] = acc[31:0]; oa[lane] = ov; end
                    1: begin eb[lane*16 +: 16] = acc[15:0]; ob[lane] = ov; end
                    default: begin ec[lane*16 +: 16] = acc[15:0]; oc[lane] = ov; end
                endcase
            end
        end
        exp_all = {ea, eb, ec, oa, ob, oc, KW'(k), KW'(k), KW'(k)};
    endtask

    // Drive beats[start..] one per cycle, optionally with random idle cycles. Returns at the
    // falling edge after the final beat has been accepted.
    task automatic send_frame(input int ksel, input int kmid, input bit gaps, input int start);
        for (int i = start; i < beats.size(); i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                imp_sel  = KW'($urandom_range(0, 31));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = (i == beats.size() - 1);
            imp_sel  = (i == 0) ? KW'(ksel) : KW'(kmid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic rand_beats(input int n);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", a_valid);
        end
        checks++;
        if (a_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", a_busy);
        end
        checks++;
        if (a_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", a_ready);
        end
        checks++;
        if (got_all() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", got_all());
        end
    endtask

    task automatic test_directed();
        int dk[5]          = '{4, 0, 4, 0, 1};
        logic [15:0] d0[5] = '{16'h000C, 16'h000C, 16'h0008, 16'h0008, 16'h0003};
        logic [15:0] d1[5] = '{16'h0004, 16'h0004, 16'h0008, 16'h0008, 16'h0001};
        logic [31:0] de[5] = '{32'h0F, 32'h10, 32'h18, 32'h10, 32'h05};
        logic [LANES*DW-1:0] v;
        for (int t = 0; t < 5; t++) begin
            beats.delete();
            v = {$urandom, $urandom}; v[15:0] = d0[t]; beats.push_back(v);
            v = {$urandom, $urandom}; v[15:0] = d1[t]; beats.push_back(v);
            send_frame(dk[t], dk[t], 1'b0, 0);
            model_frame(dk[t]);
            checks++;
            if (a_valid !== 1'b1) begin
                errors++; $display("FAIL directed_latency[%0d]: got %b want 1", t, a_valid);
            end
            checks++;
            if (a_data[31:0] !== de[t] || a_ov[0] !== 1'b0 || a_k !== KW'(dk[t])) begin
                errors++;
                $display("FAIL directed_lane0[%0d]: got %h ov=%b k=%0d want %h ov=0 k=%0d",
                         t, a_data[31:0], a_ov[0], a_k, de[t], dk[t]);
            end
            checks++;
            if (got_all() !== exp_all) begin
                errors++; $display("FAIL directed_model[%0d]: got %h want %h", t, got_all(), exp_all);
            end
            release_out();
        end
    endtask

    task automatic test_overflow();
        logic [LANES*DW-1:0] v;
        beats.delete();
        v = {$urandom, $urandom}; v[15:0] = 16'hFFFF; beats.push_back(v);
        v = {$urandom, $urandom}; v[15:0] = 16'h0001; beats.push_back(v);
        send_frame(0, 0, 1'b0, 0);
        model_frame(0);
        checks++;
        if (b_data[15:0] !== 16'hFFFF || b_ov[0] !== 1'b1) begin
            errors++; $display("FAIL ovf_saturate: got %h ov=%b want ffff ov=1", b_data[15:0], b_ov[0]);
        end
        checks++;
        if (c_data[15:0] !== 16'h0000 || c_ov[0] !== 1'b1) begin
            errors++; $display("FAIL ovf_wrap: got %h ov=%b want 0000 ov=1", c_data[15:0], c_ov[0]);
        end
        checks++;
        if (got_all() !== exp_all) begin
            errors++; $display("FAIL ovf_model: got %h want %h", got_all(), exp_all);
        end
        release_out();
        // A single-beat frame afterwards must start with clear flags and a zero-extended load.
        beats.delete();
        v = {$urandom, $urandom}; v[15:0] = 16'h0001; beats.push_back(v);
        send_frame(0, 0, 1'b0, 0);
        model_frame(0);
        checks++;
        if (b_ov !== 4'b0 || c_ov !== 4'b0 || a_data[31:0] !== 32'h1) begin
            errors++;
            $display("FAIL ovf_cleared: got b_ov=%b c_ov=%b lane0=%h want 0 0 1", b_ov, c_ov,
                     a_data[31:0]);
        end
        checks++;
        if (got_all() !== exp_all) begin
            errors++; $display("FAIL single_beat_model: got %h want %h", got_all(), exp_all);
        end
        release_out();
    endtask

    task automatic test_clamp();
        rand_beats(4);
        send_frame(31, 0, 1'b0, 0);
        model_frame(31);
        checks++;
        if (a_k !== 5'd16) begin
            errors++; $display("FAIL clamp_k: got %0d want 16", a_k);
        end
        checks++;
        if (got_all() !== exp_all) begin
            errors++; $display("FAIL clamp_model: got %h want %h", got_all(), exp_all);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [LANES*DW-1:0] next[$];
        logic [LANES*32-1:0] snap;
        for (int i = 0; i < 3; i++) next.push_back({$urandom, $urandom});
        rand_beats(3);
        send_frame(3, 3, 1'b0, 0);
        model_frame(3);
        snap = a_data;
        // Offer the first beat of the next frame while the result is held.
        in_valid = 1'b1;
        in_data  = next[0];
        in_last  = 1'b0;
        imp_sel  = 5'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (a_ready !== 1'b0 || a_valid !== 1'b1 || a_data !== snap) begin
                errors++;
                $display("FAIL hold[%0d]: got ready=%b valid=%b data=%h want 0 1 %h", i, a_ready,
                         a_valid, a_data, snap);
            end
        end
        checks++;
        if (got_all() !== exp_all) begin
            errors++; $display("FAIL hold_model: got %h want %h", got_all(), exp_all);
        end
        release_out();
        checks++;
        if (a_ready !== 1'b1 || a_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release: got ready=%b valid=%b want 1 0", a_ready, a_valid);
        end
        beats = next;
        send_frame(5, 5, 1'b0, 1);
        model_frame(5);
        checks++;
        if (a_valid !== 1'b1 || got_all() !== exp_all) begin
            errors++;
            $display("FAIL next_frame: got valid=%b %h want 1 %h", a_valid, got_all(), exp_all);
        end
        release_out();
    endtask

    task automatic test_reset_midframe();
        logic [LANES*DW-1:0] v;
        rand_beats(6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = 1'b0;
            imp_sel  = 5'd2;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b1 || a_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b busy=%b ready=%b data=%h want 0 0 1 0", a_valid,
                     a_busy, a_ready, a_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        beats.delete();
        v = {$urandom, $urandom}; v[15:0] = 16'h0002; beats.push_back(v);
        v = {$urandom, $urandom}; v[15:0] = 16'h0003; beats.push_back(v);
        send_frame(0, 0, 1'b0, 0);
        model_frame(0);
        checks++;
        if (a_data[31:0] !== 32'h5) begin
            errors++; $display("FAIL after_reset_lane0: got %h want 00000005", a_data[31:0]);
        end
        checks++;
        if (got_all() !== exp_all) begin
            errors++; $display("FAIL after_reset_model: got %h want %h", got_all(), exp_all);
        end
        release_out();
    endtask

    task automatic test_random();
        int k;
        for (int t = 0; t < 24; t++) begin
            k = $urandom_range(0, 31);
            rand_beats($urandom_range(1, 8));
            send_frame(k, $urandom_range(0, 31), 1'b1, 0);
            model_frame(k);
            checks++;
            if (a_valid !== 1'b1 || got_all() !== exp_all) begin
                errors++;
                $display("FAIL random[%0d] k=%0d: got valid=%b %h want 1 %h", t, k, a_valid,
                         got_all(), exp_all);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_out();
        end
    endtask

    initial begin
        rst       = 1'b1;
        imp_sel   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_overflow();
        test_clamp();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seta_lane_accumulator.md
Name: seta_lane_accumulator

Overview:
- Multi-lane streaming accumulator. Each lane sums a frame of unsigned DATA_WIDTH samples into an ACC_WIDTH register using the SETA approximate adder function.
- The number of approximate low-order bits, K, is chosen at run time per frame. K=0 gives an exact add.
- Sits between the approximate PE array and the output buffer. Valid/ready handshakes on both sides, saturating or wrapping overflow, sticky per-lane overflow flags.

Parameters:
- LANES, 4, number of independent accumulator lanes
- DATA_WIDTH, 16, width of each input sample (unsigned)
- ACC_WIDTH, 32, accumulator width; must be >= DATA_WIDTH
- MAX_IMPRECISE, 16, largest allowed K; must be <= DATA_WIDTH
- SATURATE, 1, 1 = clamp to all-ones on carry-out; 0 = wrap

Ports:
- clk in 1: single clock, rising edge
- rst in 1: asynchronous, active-high reset
- imp_sel in $clog2(MAX_IMPRECISE+1): requested K; sampled on the first beat of a frame
- in_valid in 1: input beat valid
- in_ready out 1: block can accept a beat
- in_data in LANES*DATA_WIDTH: lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_last in 1: marks the final beat of the frame
- out_valid out 1: result available
- out_ready in 1: downstream accepts the result
- out_data out LANES*ACC_WIDTH: lane i occupies bits [i*ACC_WIDTH +: ACC_WIDTH]
- out_overflow out LANES: sticky per-lane carry-out flag for the frame
- out_k out $clog2(MAX_IMPRECISE+1): K used for this frame
- busy out 1: state != IDLE

Behaviour:
- SETA function f(a,b,K) on ACC_WIDTH operands; b is zero-extended from DATA_WIDTH.
  - K=0: exact a+b, carry-out c.
  - K=1: s[0]=a0|b0; carry into bit 1 = a0&b0.
  - K>=2: p = a[K-2]&b[K-2]; s[K-3:0] = a|b|{p} (present only when K>2); s[K-2] = a|b; s[K-1] = a|b; carry into bit K = a[K-1]&b[K-1].
  - Bits K..ACC_WIDTH-1 form an exact ripple/behavioural add with the carry above; c is the final carry-out.
- K latch: imp_sel > MAX_IMPRECISE is clamped to MAX_IMPRECISE. The clamped value is latched into k_reg on the first accepted beat. imp_sel changes mid-frame are ignored.
- Overflow: if c=1 the lane's sticky overflow flag sets. The accumulator then takes all-ones when SATURATE=1, or the low ACC_WIDTH bits when SATURATE=0. Once saturated, the lane holds all-ones for the rest of the frame.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1. On accept: acc_i <= f(0, x_i, K), which equals x_i exactly; overflow flags cleared; next state is DONE if in_last, else ACCUM.
  - ACCUM: in_ready=1. On accept: acc_i <= f(acc_i, x_i, k_reg); next state is DONE if in_last, else stay.
  - DONE: in_ready=0, out_valid=1. out_data, out_overflow and out_k are driven from registers and held stable until out_ready. When out_ready=1, go to IDLE and clear acc.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- Throughput: 1 beat per cycle within a frame. At least one dead input cycle between frames (the DONE cycle).
- No beat is ever accepted while out_valid=1, so in_valid during DONE does not stall or corrupt the held result.
- in_valid=0 in ACCUM: hold state and accumulators; no timeout.
- Single-beat frame (in_last on the first beat): IDLE goes directly to DONE, and out_data equals the zero-extended input.
- Lanes are fully independent. All lanes share K and the handshake.
- Reset, asserted at any time including mid-frame: immediately go to IDLE with acc=0. Outputs after reset: out_valid=0, out_data=0, out_overflow=0, out_k=0, busy=0, in_ready=1.
- No combinational path from in_valid or out_ready to in_ready or out_valid; both are decoded from state.

Test Plan:
- LANES=1, K=4, beats 0x000C then 0x0004 (last) -> out_data=0x0000000F, overflow=0, out_k=4. Same beats with K=0 -> 0x00000010.
- K=4, beats 0x0008 then 0x0008 (last) -> 0x00000018; K=0 -> 0x00000010. K=1, beats 0x0003 then 0x0001 -> 0x00000005 (carry into bit 1).
- ACC_WIDTH=16, K=0, beats 0xFFFF then 0x0001: SATURATE=1 -> 0xFFFF with overflow=1; SATURATE=0 -> 0x0000 with overflow=1. A following frame with beat 0x0001 -> overflow=0.
- imp_sel=31 with MAX_IMPRECISE=16 -> out_k=16. Switch imp_sel to 0 mid-frame -> result still matches the K=16 golden model.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data stable, no beat lost. Then out_ready=1 -> next frame accepted 1 cycle later.
- Assert rst during beat 3 of a 6-beat frame -> out_valid=0 and busy=0 immediately. A fresh frame 0x0002, 0x0003 (K=0) -> 0x00000005. Randomised lanes/K against the golden f() model must match on every lane.
